// File: rtl/tt_div_pkg.sv
// Shared definitions for the sequential restoring divider.
package tt_div_pkg;

    // Default operand / result width in bits.
    localparam int DIV_WIDTH_DEFAULT = 8;

    // Divider control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage : tt_div_pkg

// File: rtl/tt_seq_divider_if.sv
// Operand and result handshake bundle for tt_seq_divider.
// The slave modport is the divider side. The master modport is the producer/consumer side.
interface tt_seq_divider_if #(
    parameter int WIDTH = tt_div_pkg::DIV_WIDTH_DEFAULT
);
    // Operand channel.
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;

    // Result channel.
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport slave (
        input  in_valid,
        input  dividend,
        input  divisor,
        input  out_ready,
        output in_ready,
        output out_valid,
        output quotient,
        output remainder,
        output div_by_zero
    );

    modport master (
        output in_valid,
        output dividend,
        output divisor,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  quotient,
        input  remainder,
        input  div_by_zero
    );

endinterface : tt_seq_divider_if

// File: rtl/tt_seq_divider_div_step.sv
// One restoring-division iteration, purely combinational.
// Shifts the next dividend bit (MSB of q) into the partial remainder.
// Then it subtracts the divisor when that does not go negative.
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   r_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH:0]   r_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH:0]   r_sh;
    logic [WIDTH-1:0] q_sh;

    assign r_sh = {r_i[WIDTH-1:0], q_i[WIDTH-1]};
    assign q_sh = {q_i[WIDTH-2:0], 1'b0};

    // Trial subtract; keep the shifted remainder if the divisor does not fit.
    always_comb begin
        r_o = r_sh;
        q_o = q_sh;
        if (r_sh >= {1'b0, divisor_i}) begin
            r_o = r_sh - {1'b0, divisor_i};
            q_o = q_sh | {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

endmodule : div_step

// File: rtl/tt_seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// The quotient register doubles as the shifting dividend during RUN.
// The partial remainder is kept one bit wider than the operands so the trial subtract cannot overflow.
module tt_seq_divider
    import tt_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    tt_seq_divider_if.slave bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    div_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic [WIDTH-1:0] dvs_q,   dvs_d;
    logic [WIDTH:0]   r_q,     r_d;
    logic [WIDTH-1:0] q_q,     q_d;
    logic             dbz_q,   dbz_d;

    logic [WIDTH:0]   step_r;
    logic [WIDTH-1:0] step_q;

    // A single step unit, reused for every RUN cycle.
    div_step #(.WIDTH(WIDTH)) u_step (
        .r_i       (r_q),
        .q_i       (q_q),
        .divisor_i (dvs_q),
        .r_o       (step_r),
        .q_o       (step_q)
    );

    // State, counter and datapath registers; reset aborts any division in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvs_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvs_q   <= dvs_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dbz_q   <= dbz_d;
        end
    end

    // Next-state and datapath update. Results hold untouched in DONE until they are taken.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvs_d   = dvs_q;
        r_d     = r_q;
        q_d     = q_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    dvs_d = bus.divisor;
                    if (bus.divisor == '0) begin
                        // Zero divisor skips iteration: all-ones quotient, dividend as remainder.
                        q_d     = '1;
                        r_d     = {1'b0, bus.dividend};
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        q_d     = bus.dividend;
                        r_d     = '0;
                        cnt_d   = CW'(WIDTH - 1);
                        dbz_d   = 1'b0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                r_d   = step_r;
                q_d   = step_q;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Every output decodes directly from registers.
    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_valid   = (state_q == DONE);
    assign bus.quotient    = q_q;
    assign bus.remainder   = r_q[WIDTH-1:0];
    assign bus.div_by_zero = dbz_q;

endmodule : tt_seq_divider

// File: tb/tb_tt_seq_divider.sv
// Self-checking bench for tt_seq_divider (WIDTH=8).
// Expected results come from plain integer / and % on the operands.
module tb_tt_seq_divider;

    localparam int W = 8;
    localparam int MAXV = (1 << W) - 1;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    tt_seq_divider_if #(.WIDTH(W)) bif ();

    tt_seq_divider #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the quotient and remainder of the operands, with zero-divisor rules.
    function automatic void ref_div(input int a, input int b, output int q, output int r, output bit z);
        if (b == 0) begin
            q = MAXV; r = a; z = 1'b1;
        end else begin
            q = a / b; r = a % b; z = 1'b0;
        end
    endfunction

    // Present operands at a falling edge, hold them across one rising edge, then drop in_valid.
    // The caller must ensure that the block is idle.
    task automatic send(input int a, input int b);
        bif.in_valid = 1'b1;
        bif.dividend = W'(a);
        bif.divisor  = W'(b);
        @(posedge clk);
        @(negedge clk);
        bif.in_valid = 1'b0;
    endtask

    // Count cycles after the accept edge until out_valid is seen (1 = the cycle after the accept).
    task automatic wait_valid(output int cyc);
        cyc = 1;
        while (!bif.out_valid && cyc < 64) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // Take the result: one edge with out_ready high.
    task automatic consume();
        bif.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bif.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bif.in_valid = 1'b1;
        bif.dividend = 8'd9;
        bif.divisor  = 8'd3;
        repeat (3) @(negedge clk);
        checks++;
        if (bif.out_valid !== 1'b0 || bif.quotient !== 8'd0 || bif.remainder !== 8'd0 ||
            bif.div_by_zero !== 1'b0 || bif.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: ov=%b q=%0d r=%0d dbz=%0d ir=%b, want 0 0 0 0 1",
                     bif.out_valid, bif.quotient, bif.remainder, bif.div_by_zero, bif.in_ready);
        end
        bif.in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bif.in_ready !== 1'b1 || bif.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ignored_hs: ir=%b ov=%b, want 1 0", bif.in_ready, bif.out_valid);
        end
    endtask

    task automatic test_basic();
        int cyc;
        send(200, 7);
        wait_valid(cyc);
        checks++;
        if (cyc !== W + 1) begin
            errors++;
            $display("FAIL basic_latency: got %0d want %0d", cyc, W + 1);
        end
        checks++;
        if (bif.quotient !== 8'd28 || bif.remainder !== 8'd4 || bif.div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL basic_200_7: q=%0d r=%0d dbz=%0d, want 28 4 0",
                     bif.quotient, bif.remainder, bif.div_by_zero);
        end
        consume();
        checks++;
        if (bif.in_ready !== 1'b1 || bif.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_return_idle: ir=%b ov=%b, want 1 0", bif.in_ready, bif.out_valid);
        end
    endtask

    task automatic test_div_zero();
        int cyc;
        send(13, 0);
        wait_valid(cyc);
        checks++;
        if (cyc !== 1) begin
            errors++;
            $display("FAIL dbz_latency: got %0d want 1", cyc);
        end
        checks++;
        if (bif.quotient !== 8'd255 || bif.remainder !== 8'd13 || bif.div_by_zero !== 1'b1) begin
            errors++;
            $display("FAIL dbz_13_0: q=%0d r=%0d dbz=%0d, want 255 13 1",
                     bif.quotient, bif.remainder, bif.div_by_zero);
        end
        consume();
    endtask

    task automatic test_boundary();
        int ta[3] = '{5, 255, 0};
        int tb[3] = '{9, 1, 3};
        int cyc, eq, er;
        bit ez;
        for (int i = 0; i < 3; i++) begin
            ref_div(ta[i], tb[i], eq, er, ez);
            send(ta[i], tb[i]);
            wait_valid(cyc);
            checks++;
            if (!bif.out_valid || int'(bif.quotient) !== eq || int'(bif.remainder) !== er ||
                bif.div_by_zero !== ez) begin
                errors++;
                $display("FAIL boundary_%0d_%0d: ov=%b q=%0d r=%0d dbz=%0d, want 1 %0d %0d %0d",
                         ta[i], tb[i], bif.out_valid, bif.quotient, bif.remainder,
                         bif.div_by_zero, eq, er, ez);
            end
            consume();
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        send(100, 10);
        wait_valid(cyc);
        // A second request shows up while the result is held.
        bif.in_valid = 1'b1;
        bif.dividend = 8'd77;
        bif.divisor  = 8'd3;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bif.out_valid !== 1'b1 || bif.quotient !== 8'd10 || bif.remainder !== 8'd0 ||
                bif.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_%0d: ov=%b q=%0d r=%0d ir=%b, want 1 10 0 0",
                         i, bif.out_valid, bif.quotient, bif.remainder, bif.in_ready);
            end
            @(negedge clk);
        end
        bif.in_valid = 1'b0;
        consume();
        // Nothing from the ignored request may surface.
        repeat (12) begin
            checks++;
            if (bif.out_valid !== 1'b0 || bif.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL hold_ignored_req: ov=%b ir=%b, want 0 1", bif.out_valid, bif.in_ready);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_abort();
        int cyc;
        send(200, 7);
        repeat (3) @(negedge clk);   // now in the 4th RUN cycle
        rst = 1'b1;
        #1;
        checks++;
        if (bif.out_valid !== 1'b0 || bif.quotient !== 8'd0 || bif.remainder !== 8'd0 ||
            bif.div_by_zero !== 1'b0 || bif.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_state: ov=%b q=%0d r=%0d dbz=%0d ir=%b, want 0 0 0 0 1",
                     bif.out_valid, bif.quotient, bif.remainder, bif.div_by_zero, bif.in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send(50, 6);
        wait_valid(cyc);
        checks++;
        if (!bif.out_valid || bif.quotient !== 8'd8 || bif.remainder !== 8'd2 || bif.div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL abort_then_50_6: ov=%b q=%0d r=%0d dbz=%0d, want 1 8 2 0",
                     bif.out_valid, bif.quotient, bif.remainder, bif.div_by_zero);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        int a, b, eq, er, guard;
        bit ez, taken;
        int   bad_before;
        bad_before = errors;
        for (int n = 0; n < 1000; n++) begin
            a = int'($urandom_range(0, MAXV));
            b = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, MAXV));
            ref_div(a, b, eq, er, ez);
            checks++;
            if (bif.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready_%0d: ir=%b want 1", n, bif.in_ready);
            end
            send(a, b);
            taken = 1'b0;
            guard = 0;
            while (!taken && guard < 64) begin
                if (bif.out_valid) begin
                    checks++;
                    if (int'(bif.quotient) !== eq || int'(bif.remainder) !== er || bif.div_by_zero !== ez) begin
                        errors++;
                        $display("FAIL b2b_%0d_%0d: q=%0d r=%0d dbz=%0d, want %0d %0d %0d",
                                 a, b, bif.quotient, bif.remainder, bif.div_by_zero, eq, er, ez);
                    end
                    if (b != 0) begin
                        checks++;
                        if (int'(bif.quotient) * b + int'(bif.remainder) != a || int'(bif.remainder) >= b) begin
                            errors++;
                            $display("FAIL b2b_invariant_%0d_%0d: q=%0d r=%0d", a, b,
                                     bif.quotient, bif.remainder);
                        end
                    end
                    bif.out_ready = 1'($urandom_range(0, 1));
                    taken = bif.out_ready;
                end else begin
                    bif.out_ready = 1'($urandom_range(0, 1));
                end
                @(posedge clk);
                @(negedge clk);
                guard++;
            end
            bif.out_ready = 1'b0;
            checks++;
            if (!taken) begin
                errors++;
                $display("FAIL b2b_timeout_%0d: no result for %0d/%0d", n, a, b);
            end
            if (errors - bad_before > 20) begin
                $display("FAIL b2b_abort: too many errors, stopping random phase");
                break;
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bif.in_valid  = 1'b0;
        bif.dividend  = '0;
        bif.divisor   = '0;
        bif.out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_div_zero();
        test_boundary();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_tt_seq_divider
